// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Control sequencer for a multi-cycle LEGv8 datapath. The datapath has one
//   ALU, one unified memory, a register file and PC/IR/ALUOut/MDR registers.
//   Supported instructions: R-type (ADD/SUB/AND/ORR), LDUR, STUR and CBZ.
//   The sequencer stalls while memory is not ready. It moves to a sticky fault
//   state on an illegal opcode or on a memory wait timeout, and it counts
//   retired instructions.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   opcode[10:0]      IR[31:21], valid from DECODE onward
//   zero              ALU zero flag (CBZ condition)
//   mem_ready         memory completes the current access this cycle
//   pc_we, ir_write, mem_read, mem_write, reg_write
//                     datapath strobes, forced low while rst_n is low
//   i_or_d, mem_to_reg, reg2loc, alu_src_a, alu_src_b[1:0], alu_op[1:0],
//   pc_source         datapath mux selects
//   state[3:0]        current state encoding (debug)
//   fault             high in ILLEGAL or TIMEOUT
//   instr_count       retired-instruction counter, wraps
module multicycle_control_fsm #(
  parameter int WAIT_LIMIT = 15,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [10:0]        opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_we,
  output logic               ir_write,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               reg2loc,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               pc_source,
  output logic [3:0]         state,
  output logic               fault,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BR_COMP  = 4'd8,
    ILLEGAL  = 4'd9,
    TIMEOUT  = 4'd10
  } stateT;

  // The wait counter only needs to reach WAIT_LIMIT-1.
  localparam int WAIT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (WAIT_LIMIT == 0) ? '0 : WAIT_W'(WAIT_LIMIT - 1);

  stateT              stateReg, stateNext;
  logic [WAIT_W-1:0]  waitCntReg, waitCntNext;
  logic [COUNT_W-1:0] countReg;

  logic isR, isLd, isSt, isCb;
  logic pcWrite, pcWriteCond, retire, waitExpired;
  logic irWriteRaw, memReadRaw, memWriteRaw, regWriteRaw;

  // Opcode classes.
  always_comb begin
    isR  = 1'b0;
    isLd = 1'b0;
    isSt = 1'b0;
    isCb = 1'b0;
    casez (opcode)
      11'b1??0101?000: isR  = 1'b1;
      11'b11111000010: isLd = 1'b1;
      11'b11111000000: isSt = 1'b1;
      11'b10110100???: isCb = 1'b1;
      default:         ;
    endcase
  end

  // The ready check happens before this flag is used, so ready wins in the
  // last allowed wait cycle.
  assign waitExpired = (WAIT_LIMIT != 0) && (waitCntReg == WAIT_LAST);

  always_comb begin
    stateNext   = stateReg;
    waitCntNext = '0;
    retire      = 1'b0;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    irWriteRaw  = 1'b0;
    memReadRaw  = 1'b0;
    memWriteRaw = 1'b0;
    regWriteRaw = 1'b0;
    i_or_d      = 1'b0;
    mem_to_reg  = 1'b0;
    reg2loc     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    pc_source   = 1'b0;
    fault       = 1'b0;
    case (stateReg)
      FETCH: begin
        memReadRaw = 1'b1;
        alu_src_b  = 2'b01;
        if (mem_ready) begin
          irWriteRaw = 1'b1;
          pcWrite    = 1'b1;
          stateNext  = DECODE;
        end else if (waitExpired) begin
          stateNext = TIMEOUT;
        end else begin
          waitCntNext = waitCntReg + 1'b1;
        end
      end
      DECODE: begin
        // The branch target is computed early into ALUOut.
        alu_src_b = 2'b11;
        reg2loc   = isSt | isCb;
        if (isR)             stateNext = R_EXEC;
        else if (isLd | isSt) stateNext = MEM_ADDR;
        else if (isCb)       stateNext = BR_COMP;
        else                 stateNext = ILLEGAL;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        reg2loc   = isSt;
        if (isLd)      stateNext = MEM_RD;
        else if (isSt) stateNext = MEM_WR;
        else           stateNext = ILLEGAL;
      end
      MEM_RD: begin
        memReadRaw = 1'b1;
        i_or_d     = 1'b1;
        if (mem_ready)        stateNext = MEM_WB;
        else if (waitExpired) stateNext = TIMEOUT;
        else                  waitCntNext = waitCntReg + 1'b1;
      end
      MEM_WB: begin
        regWriteRaw = 1'b1;
        mem_to_reg  = 1'b1;
        retire      = 1'b1;
        stateNext   = FETCH;
      end
      MEM_WR: begin
        memWriteRaw = 1'b1;
        i_or_d      = 1'b1;
        reg2loc     = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          stateNext = FETCH;
        end else if (waitExpired) begin
          stateNext = TIMEOUT;
        end else begin
          waitCntNext = waitCntReg + 1'b1;
        end
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        stateNext = R_WB;
      end
      R_WB: begin
        regWriteRaw = 1'b1;
        retire      = 1'b1;
        stateNext   = FETCH;
      end
      BR_COMP: begin
        // A not-taken branch still retires.
        alu_src_a   = 1'b1;
        alu_op      = 2'b01;
        reg2loc     = 1'b1;
        pcWriteCond = 1'b1;
        pc_source   = 1'b1;
        retire      = 1'b1;
        stateNext   = FETCH;
      end
      ILLEGAL, TIMEOUT: fault = 1'b1;
      default: stateNext = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= FETCH;
      waitCntReg <= '0;
      countReg   <= '0;
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
      if (retire) countReg <= countReg + 1'b1;
    end
  end

  // Gate the strobes with rst_n. Reset forces the state to FETCH, and FETCH
  // would otherwise assert mem_read immediately.
  assign pc_we       = rst_n & (pcWrite | (pcWriteCond & zero));
  assign ir_write    = rst_n & irWriteRaw;
  assign mem_read    = rst_n & memReadRaw;
  assign mem_write   = rst_n & memWriteRaw;
  assign reg_write   = rst_n & regWriteRaw;
  assign state       = stateReg;
  assign instr_count = countReg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. Inputs change just after the
// falling edge, and outputs are sampled 1 ns later, before the next rising edge.
module tb_multicycle_control_fsm;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_LD  = 11'b11111000010;
  localparam logic [10:0] OP_ST  = 11'b11111000000;
  localparam logic [10:0] OP_CB  = 11'b10110100101;
  localparam logic [10:0] OP_BAD = 11'b00000000000;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  logic [10:0] opcode = '0;
  logic zero = 1'b0;
  logic memReady = 1'b0;

  logic pcWe, irWrite, iOrD, memRead, memWrite, memToReg, regWrite, reg2loc;
  logic aluSrcA, pcSource, fault;
  logic [1:0] aluSrcB, aluOp;
  logic [3:0] state;
  logic [15:0] instrCount;

  logic wPcWe, wIrWrite, wIOrD, wMemRead, wMemWrite, wMemToReg, wRegWrite;
  logic wReg2loc, wAluSrcA, wPcSource, wFault;
  logic [1:0] wAluSrcB, wAluOp;
  logic [3:0] wState;
  logic [1:0] wInstrCount;

  int nChecks = 0;
  int nFails  = 0;
  int expCount = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.WAIT_LIMIT(15), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rstN), .opcode(opcode), .zero(zero), .mem_ready(memReady),
    .pc_we(pcWe), .ir_write(irWrite), .i_or_d(iOrD), .mem_read(memRead),
    .mem_write(memWrite), .mem_to_reg(memToReg), .reg_write(regWrite),
    .reg2loc(reg2loc), .alu_src_a(aluSrcA), .alu_src_b(aluSrcB), .alu_op(aluOp),
    .pc_source(pcSource), .state(state), .fault(fault), .instr_count(instrCount)
  );

  multicycle_control_fsm #(.WAIT_LIMIT(15), .COUNT_W(2)) dutW (
    .clk(clk), .rst_n(rstN), .opcode(opcode), .zero(zero), .mem_ready(memReady),
    .pc_we(wPcWe), .ir_write(wIrWrite), .i_or_d(wIOrD), .mem_read(wMemRead),
    .mem_write(wMemWrite), .mem_to_reg(wMemToReg), .reg_write(wRegWrite),
    .reg2loc(wReg2loc), .alu_src_a(wAluSrcA), .alu_src_b(wAluSrcB), .alu_op(wAluOp),
    .pc_source(wPcSource), .state(wState), .fault(wFault), .instr_count(wInstrCount)
  );

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  // Leaves the bench in the first FETCH cycle, before the next rising edge.
  task automatic doReset();
    nextCycle();
    rstN = 1'b0;
    nextCycle();
    rstN = 1'b1;
    expCount = 0;
    #1;
  endtask

  task automatic test_reset();
    memReady = 1'b1;
    rstN = 1'b0;
    nextCycle();
    nChecks++; if (state !== 4'd0) begin nFails++; $display("FAIL reset_state got %0d want 0", state); end
    nChecks++; if (instrCount !== 16'd0) begin nFails++; $display("FAIL reset_count got %0d want 0", instrCount); end
    nChecks++; if ({pcWe, irWrite, memRead, memWrite, regWrite} !== 5'b0) begin
      nFails++; $display("FAIL reset_strobes got %b want 00000", {pcWe, irWrite, memRead, memWrite, regWrite}); end
    nChecks++; if (fault !== 1'b0) begin nFails++; $display("FAIL reset_fault got %b want 0", fault); end
    rstN = 1'b1;
    #1;
    nChecks++; if ({memRead, irWrite, pcWe, aluSrcB} !== 5'b11101) begin
      nFails++; $display("FAIL fetch_outputs got %b want 11101", {memRead, irWrite, pcWe, aluSrcB}); end
    $display("reset: state=%0d count=%0d", state, instrCount);
  endtask

  task automatic test_add();
    logic [3:0] expState [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic       expRegWr [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    doReset();
    opcode = OP_ADD; memReady = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      nChecks++; if (state !== expState[c]) begin nFails++; $display("FAIL add_state c%0d got %0d want %0d", c, state, expState[c]); end
      nChecks++; if (regWrite !== expRegWr[c]) begin nFails++; $display("FAIL add_reg_write c%0d got %b want %b", c, regWrite, expRegWr[c]); end
      if (c == 2) begin
        nChecks++; if (aluOp !== 2'b10) begin nFails++; $display("FAIL add_alu_op got %b want 10", aluOp); end
      end
      if (c == 3) expCount++;
      if (c < 4) nextCycle();
    end
    nChecks++; if (instrCount !== expCount[15:0]) begin nFails++; $display("FAIL add_count got %0d want %0d", instrCount, expCount); end
    $display("ADD: count=%0d", instrCount);
  endtask

  task automatic test_ldur();
    logic       rdy [8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] expSt [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    doReset();
    opcode = OP_LD;
    for (int c = 0; c < 8; c++) begin
      memReady = rdy[c];
      #1;
      nChecks++; if (state !== expSt[c]) begin nFails++; $display("FAIL ld_state c%0d got %0d want %0d", c, state, expSt[c]); end
      if (c >= 3 && c <= 6) begin
        nChecks++; if ({memRead, iOrD} !== 2'b11) begin nFails++; $display("FAIL ld_mem_rd c%0d got %b want 11", c, {memRead, iOrD}); end
      end
      if (c == 7) begin
        nChecks++; if ({memToReg, regWrite} !== 2'b11) begin nFails++; $display("FAIL ld_wb got %b want 11", {memToReg, regWrite}); end
        expCount++;
      end
      nextCycle();
    end
    nChecks++; if (state !== 4'd0) begin nFails++; $display("FAIL ld_return got %0d want 0", state); end
    nChecks++; if (instrCount !== expCount[15:0]) begin nFails++; $display("FAIL ld_count got %0d want %0d", instrCount, expCount); end
    $display("LDUR: count=%0d", instrCount);
  endtask

  task automatic test_cbz();
    logic zv [2] = '{1'b1, 1'b0};
    doReset();
    opcode = OP_CB; memReady = 1'b1;
    for (int k = 0; k < 2; k++) begin
      zero = zv[k];
      #1;
      nChecks++; if (state !== 4'd0) begin nFails++; $display("FAIL cb_fetch z%0d got %0d want 0", zv[k], state); end
      nextCycle();
      nChecks++; if ({state, reg2loc, aluSrcB} !== {4'd1, 1'b1, 2'b11}) begin
        nFails++; $display("FAIL cb_decode got %b want 0001111", {state, reg2loc, aluSrcB}); end
      nextCycle();
      nChecks++; if (state !== 4'd8) begin nFails++; $display("FAIL cb_state got %0d want 8", state); end
      nChecks++; if (pcWe !== zv[k]) begin nFails++; $display("FAIL cb_pc_we z%0d got %b want %b", zv[k], pcWe, zv[k]); end
      nChecks++; if ({pcSource, aluOp, aluSrcA} !== 4'b1011) begin nFails++; $display("FAIL cb_sel got %b want 1011", {pcSource, aluOp, aluSrcA}); end
      expCount++;
      nextCycle();
      $display("CBZ zero=%0b: pc_we seen, count now %0d", zv[k], instrCount);
    end
    nChecks++; if (state !== 4'd0) begin nFails++; $display("FAIL cb_return got %0d want 0", state); end
    nChecks++; if (instrCount !== expCount[15:0]) begin nFails++; $display("FAIL cb_count got %0d want %0d", instrCount, expCount); end
  endtask

  task automatic test_illegal();
    doReset();
    opcode = OP_BAD; memReady = 1'b1;
    nextCycle();
    nChecks++; if (state !== 4'd1) begin nFails++; $display("FAIL ill_decode got %0d want 1", state); end
    nextCycle();
    for (int c = 0; c < 20; c++) begin
      nChecks++; if ({state, fault} !== {4'd9, 1'b1}) begin nFails++; $display("FAIL ill_sticky c%0d got %b want 10011", c, {state, fault}); end
      nChecks++; if ({pcWe, irWrite, memRead, memWrite, regWrite} !== 5'b0) begin
        nFails++; $display("FAIL ill_strobes c%0d got %b want 00000", c, {pcWe, irWrite, memRead, memWrite, regWrite}); end
      nextCycle();
    end
    doReset();
    nChecks++; if ({state, fault} !== 5'b00000) begin nFails++; $display("FAIL ill_recover got %b want 00000", {state, fault}); end
    nChecks++; if (instrCount !== 16'd0) begin nFails++; $display("FAIL ill_count got %0d want 0", instrCount); end
    $display("ILLEGAL: recovered state=%0d", state);
  endtask

  task automatic test_timeout();
    doReset();
    opcode = OP_ADD; memReady = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      #1;
      nChecks++; if ({state, fault} !== 5'b00000) begin nFails++; $display("FAIL to_wait c%0d got %b want 00000", c, {state, fault}); end
      nextCycle();
    end
    nChecks++; if ({state, fault} !== {4'd10, 1'b1}) begin nFails++; $display("FAIL to_enter got %b want 10101", {state, fault}); end
    $display("TIMEOUT: entered state=%0d", state);
    doReset();
    for (int c = 1; c <= 15; c++) begin
      memReady = (c == 15);
      #1;
      if (c == 15) begin
        nChecks++; if (irWrite !== 1'b1) begin nFails++; $display("FAIL to_last_ready got %b want 1", irWrite); end
      end
      nextCycle();
    end
    nChecks++; if ({state, fault} !== {4'd1, 1'b0}) begin nFails++; $display("FAIL to_ready_wins got %b want 00010", {state, fault}); end
    $display("TIMEOUT: ready on last cycle, state=%0d", state);
  endtask

  task automatic test_stur_reset();
    doReset();
    opcode = OP_ADD; memReady = 1'b1;
    repeat (4) nextCycle();
    opcode = OP_ST;
    nextCycle();
    nextCycle();
    nChecks++; if ({state, reg2loc} !== {4'd2, 1'b1}) begin nFails++; $display("FAIL st_addr got %b want 00101", {state, reg2loc}); end
    nextCycle();
    nChecks++; if ({state, memWrite, iOrD} !== {4'd5, 2'b11}) begin nFails++; $display("FAIL st_wr got %b want 010111", {state, memWrite, iOrD}); end
    nextCycle();
    nChecks++; if (instrCount !== 16'd2) begin nFails++; $display("FAIL st_count got %0d want 2", instrCount); end
    nextCycle();
    nextCycle();
    memReady = 1'b0;
    nextCycle();
    nChecks++; if ({state, memWrite} !== {4'd5, 1'b1}) begin nFails++; $display("FAIL st_hold got %b want 01011", {state, memWrite}); end
    #1 rstN = 1'b0;
    #1;
    nChecks++; if (memWrite !== 1'b0) begin nFails++; $display("FAIL st_async_drop got %b want 0", memWrite); end
    nChecks++; if ({state, instrCount} !== 20'd0) begin nFails++; $display("FAIL st_async_state got %0d/%0d want 0/0", state, instrCount); end
    nextCycle();
    rstN = 1'b1;
    $display("STUR: async reset mid-write, state=%0d count=%0d", state, instrCount);
  endtask

  task automatic test_back_to_back();
    doReset();
    opcode = OP_ADD; memReady = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      #1;
      if (c == 12) begin
        nChecks++; if (wInstrCount !== 2'd3) begin nFails++; $display("FAIL wrap_pre got %0d want 3", wInstrCount); end
      end
      if (c == 16) begin
        nChecks++; if (wInstrCount !== 2'd0) begin nFails++; $display("FAIL wrap_zero got %0d want 0", wInstrCount); end
        nChecks++; if (instrCount !== 16'd4) begin nFails++; $display("FAIL wrap_wide got %0d want 4", instrCount); end
      end
      if (c < 16) nextCycle();
    end
    $display("back_to_back: 4 ADDs, narrow=%0d wide=%0d", wInstrCount, instrCount);
  endtask

  initial begin
    test_reset();
    test_add();
    test_ldur();
    test_cbz();
    test_illegal();
    test_timeout();
    test_stur_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
